// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Contents: FSM state enum, alignment helpers, increment legality check.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int unsigned DEFAULT_INC = 4;
  localparam int unsigned ALIGN_LSB   = $clog2(DEFAULT_INC);

  // Number of low PC bits that must be zero for a given increment.
  function automatic int unsigned align_lsb(input int unsigned inc);
    return $clog2(inc);
  endfunction

  // Only 16-bit (compressed) and 32-bit instruction steps make sense.
  function automatic bit inc_legal(input int unsigned inc);
    return (inc == 2) || (inc == 4);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration for pc_gen: picks trap > jump > pending and decides
// whether the winner is applied now or parked while the pipeline is held.
// Ports:
//   trap_en/trap_addr   trap request and vector (low bits forced to zero)
//   jump_en/jump_addr   jump request and target
//   jump_block          ignore jumps (core is in FAULT)
//   hold                pipeline stall
//   pend_*              current pending-redirect register contents
//   load                apply sel_addr to the PC this edge
//   sel_addr/sel_trap   chosen target and whether it came from a trap
//   sel_misaligned      chosen target has nonzero low bits
//   pend_*_nxt          next pending-register contents
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LSB  = 2
) (
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            jump_block,
  input  logic            hold,
  input  logic            pend_valid,
  input  logic            pend_trap,
  input  logic [XLEN-1:0] pend_addr,
  output logic            load,
  output logic [XLEN-1:0] sel_addr,
  output logic            sel_trap,
  output logic            sel_misaligned,
  output logic            pend_valid_nxt,
  output logic            pend_trap_nxt,
  output logic [XLEN-1:0] pend_addr_nxt
);

  localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-LSB){1'b0}}, {LSB{1'b1}}};

  logic [XLEN-1:0] trap_tgt;
  logic            jump_ok;

  assign trap_tgt       = trap_addr & ~LOW_MASK;
  assign jump_ok        = jump_en && !jump_block;
  assign sel_misaligned = |(sel_addr & LOW_MASK);

  always_comb begin
    load           = 1'b0;
    sel_addr       = pend_addr;
    sel_trap       = pend_trap;
    pend_valid_nxt = pend_valid;
    pend_trap_nxt  = pend_trap;
    pend_addr_nxt  = pend_addr;
    if (hold) begin
      // A parked trap must never be displaced by a younger jump.
      if (trap_en) begin
        pend_valid_nxt = 1'b1;
        pend_trap_nxt  = 1'b1;
        pend_addr_nxt  = trap_tgt;
      end else if (jump_ok && !(pend_valid && pend_trap)) begin
        pend_valid_nxt = 1'b1;
        pend_trap_nxt  = 1'b0;
        pend_addr_nxt  = jump_addr;
      end
    end else begin
      pend_valid_nxt = 1'b0;
      pend_trap_nxt  = 1'b0;
      pend_addr_nxt  = '0;
      if (trap_en) begin
        load     = 1'b1;
        sel_addr = trap_tgt;
        sel_trap = 1'b1;
      end else if (jump_ok) begin
        load     = 1'b1;
        sel_addr = jump_addr;
        sel_trap = 1'b0;
      end else if (pend_valid) begin
        load = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Issues sequential fetch addresses over a valid/ready handshake, applies
// trap/jump redirects (parking them while the pipeline is held) and stops
// in a fault state on a misaligned jump target until a trap arrives.
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   hold_i                     pipeline stall
//   jump_en_i / jump_addr_i    jump redirect request
//   trap_en_i / trap_addr_i    trap redirect request (wins over jump)
//   pc_ready_i                 fetch side accepts pc_o
//   pc_valid_o / pc_o          fetch request and address
//   redirect_o                 one-cycle pulse after a redirect is loaded
//   misalign_o                 core is in FAULT due to a misaligned jump
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | issuing sequential fetch addresses
// FAULT | stopped on a misaligned jump target, waiting for a trap
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int unsigned     INC         = 4,
  parameter bit              ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            pc_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  localparam int unsigned LSB = (INC == DEFAULT_INC) ? ALIGN_LSB : align_lsb(INC);

  generate
    if (!inc_legal(INC)) begin : g_bad_inc
      $error("pc_gen: INC must be 2 or 4");
    end
  endgenerate

  pc_state_e       state;
  logic            pend_valid;
  logic            pend_trap;
  logic [XLEN-1:0] pend_addr;

  logic            load;
  logic [XLEN-1:0] sel_addr;
  logic            sel_trap;
  logic            sel_misaligned;
  logic            pend_valid_nxt;
  logic            pend_trap_nxt;
  logic [XLEN-1:0] pend_addr_nxt;
  logic            bad_target;

  pc_redirect_arb #(
    .XLEN (XLEN),
    .LSB  (LSB)
  ) u_arb (
    .trap_en        (trap_en_i),
    .trap_addr      (trap_addr_i),
    .jump_en        (jump_en_i),
    .jump_addr      (jump_addr_i),
    .jump_block     (state == FAULT),
    .hold           (hold_i),
    .pend_valid     (pend_valid),
    .pend_trap      (pend_trap),
    .pend_addr      (pend_addr),
    .load           (load),
    .sel_addr       (sel_addr),
    .sel_trap       (sel_trap),
    .sel_misaligned (sel_misaligned),
    .pend_valid_nxt (pend_valid_nxt),
    .pend_trap_nxt  (pend_trap_nxt),
    .pend_addr_nxt  (pend_addr_nxt)
  );

  // Request may be withdrawn by hold_i; the instruction ROM is stateless.
  assign pc_valid_o = (state == RUN) && !hold_i && !pend_valid;

  // Trap targets are already aligned by the arbiter; only jumps can fault.
  assign bad_target = ALIGN_CHECK && !sel_trap && sel_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_o       <= RESET_ADDR;
      redirect_o <= 1'b0;
      misalign_o <= 1'b0;
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
      pend_addr  <= '0;
    end else begin
      redirect_o <= 1'b0;
      pend_valid <= pend_valid_nxt;
      pend_trap  <= pend_trap_nxt;
      pend_addr  <= pend_addr_nxt;
      if (load) begin
        if (bad_target) begin
          state      <= FAULT;
          misalign_o <= 1'b1;
        end else begin
          // Any handshake in this same cycle is treated as consumed.
          state      <= RUN;
          pc_o       <= sel_addr;
          redirect_o <= 1'b1;
          misalign_o <= 1'b0;
        end
      end else begin
        case (state)
          BOOT:    state <= RUN;
          RUN:     if (pc_valid_o && pc_ready_i) pc_o <= pc_o + XLEN'(INC);
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        trap_en;
  logic [31:0] trap_addr;
  logic        pc_ready;
  logic        pc_valid;
  logic [31:0] pc;
  logic        redirect;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  logic        sb_en = 1'b0;

  pc_gen #(
    .XLEN        (32),
    .RESET_ADDR  (32'h0000_0100),
    .INC         (4),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_i      (hold),
    .jump_en_i   (jump_en),
    .jump_addr_i (jump_addr),
    .trap_en_i   (trap_en),
    .trap_addr_i (trap_addr),
    .pc_ready_i  (pc_ready),
    .pc_valid_o  (pc_valid),
    .pc_o        (pc),
    .redirect_o  (redirect),
    .misalign_o  (misalign)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (sb_en && rst_n && pc_valid && pc_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: issued pc=%h, none expected", pc);
      end else begin
        exp_pc = sb_q.pop_front();
        if (pc !== exp_pc) begin
          n_fail++;
          $display("FAIL sb_pc: got %h expected %h", pc, exp_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; trap_en = 1'b0;
    jump_addr = '0; trap_addr = '0; pc_ready = 1'b1;
    #12;
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rst_pc: got %h expected 00000100", pc); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", pc_valid); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b expected 0", redirect); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", misalign); end
    cyc();
    rst_n = 1'b1;
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    sb_q.push_back(32'h108);
    sb_en = 1'b1;
    @(negedge clk);
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", pc_valid); end
    repeat (4) cyc();
    pc_ready = 1'b0;
    sb_en = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL boot_seq_left: got %0d expected 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    jump_en = 1'b1; jump_addr = 32'h20;
    cyc();
    jump_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h expected 00000020", i, pc); end
      n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, pc_valid); end
      n_checks++; if (redirect !== (i == 0)) begin n_fail++; $display("FAIL bp_redirect[%0d]: got %b expected %b", i, redirect, i == 0); end
      cyc();
    end
    sb_q.push_back(32'h20);
    sb_q.push_back(32'h24);
    sb_en = 1'b1; pc_ready = 1'b1;
    cyc();
    cyc();
    pc_ready = 1'b0; sb_en = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL bp_seq_left: got %0d expected 0", sb_q.size()); end
    n_checks++; if (pc !== 32'h28) begin n_fail++; $display("FAIL bp_next_pc: got %h expected 00000028", pc); end
  endtask

  task automatic test_priority();
    // The fetch of 0x28 completing alongside the redirect counts as consumed.
    sb_q.push_back(32'h28);
    sb_q.push_back(32'h800);
    sb_q.push_back(32'h804);
    sb_en = 1'b1; pc_ready = 1'b1;
    jump_en = 1'b1; jump_addr = 32'h400;
    trap_en = 1'b1; trap_addr = 32'h800;
    cyc();
    jump_en = 1'b0; trap_en = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h800) begin n_fail++; $display("FAIL prio_pc: got %h expected 00000800", pc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL prio_redirect: got %b expected 1", redirect); end
    cyc();
    @(negedge clk);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL prio_redirect_end: got %b expected 0", redirect); end
    cyc();
    pc_ready = 1'b0; sb_en = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL prio_seq_left: got %0d expected 0", sb_q.size()); end
    // Unaligned trap vector has its low bits dropped.
    trap_en = 1'b1; trap_addr = 32'h90E;
    cyc();
    trap_en = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h90C) begin n_fail++; $display("FAIL trap_align: got %h expected 0000090c", pc); end
  endtask

  task automatic test_held_redirect();
    cyc();
    hold = 1'b1;
    jump_en = 1'b1; jump_addr = 32'h40;
    cyc();
    jump_en = 1'b0;
    trap_en = 1'b1; trap_addr = 32'h80;
    cyc();
    trap_en = 1'b0;
    jump_en = 1'b1; jump_addr = 32'h60;
    cyc();
    jump_en = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h90C) begin n_fail++; $display("FAIL hold_pc: got %h expected 0000090c", pc); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", pc_valid); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL hold_redirect: got %b expected 0", redirect); end
    cyc();
    hold = 1'b0;
    sb_q.push_back(32'h80);
    sb_q.push_back(32'h84);
    sb_en = 1'b1; pc_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b expected 0", pc_valid); end
    cyc();
    @(negedge clk);
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL release_pc: got %h expected 00000080", pc); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL release_redirect: got %b expected 1", redirect); end
    cyc();
    cyc();
    pc_ready = 1'b0; sb_en = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL held_seq_left: got %0d expected 0", sb_q.size()); end
  endtask

  task automatic test_misalign();
    jump_en = 1'b1; jump_addr = 32'h102;
    cyc();
    jump_en = 1'b0;
    @(negedge clk);
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", misalign); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b expected 0", pc_valid); end
    n_checks++; if (pc !== 32'h88) begin n_fail++; $display("FAIL mis_pc: got %h expected 00000088", pc); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL mis_redirect: got %b expected 0", redirect); end
    cyc();
    jump_en = 1'b1; jump_addr = 32'h300;
    cyc();
    jump_en = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h88) begin n_fail++; $display("FAIL fault_jump_pc: got %h expected 00000088", pc); end
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL fault_jump_flag: got %b expected 1", misalign); end
    cyc();
    trap_en = 1'b1; trap_addr = 32'h200;
    cyc();
    trap_en = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL fault_exit_pc: got %h expected 00000200", pc); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL fault_exit_flag: got %b expected 0", misalign); end
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL fault_exit_redirect: got %b expected 1", redirect); end
    n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL fault_exit_valid: got %b expected 1", pc_valid); end
  endtask

  task automatic test_wrap_reset();
    cyc();
    trap_en = 1'b1; trap_addr = 32'hFFFF_FFFC;
    cyc();
    trap_en = 1'b0;
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_en = 1'b1; pc_ready = 1'b1;
    repeat (3) cyc();
    pc_ready = 1'b0; sb_en = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL wrap_seq_left: got %0d expected 0", sb_q.size()); end
    n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00000008", pc); end
    hold = 1'b1;
    trap_en = 1'b1; trap_addr = 32'h500;
    cyc();
    trap_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL async_rst_pc: got %h expected 00000100", pc); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", pc_valid); end
    hold = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reboot_valid: got %b expected 0", pc_valid); end
    cyc();
    @(negedge clk);
    n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL reboot_run_valid: got %b expected 1", pc_valid); end
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL reboot_pc: got %h expected 00000100", pc); end
    cyc();
    @(negedge clk);
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL stale_trap_pc: got %h expected 00000100", pc); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL stale_trap_redirect: got %b expected 0", redirect); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_priority();
    test_held_redirect();
    test_misalign();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core's fetch stage, and the next-generation replacement for the fixed 32-bit PC register. It adds:
- configurable width, reset vector and increment;
- a valid/ready request handshake toward instruction memory;
- two-level redirect priority (trap over jump);
- redirect capture while the pipeline is held;
- a misaligned-target fault state.

It sits between the control/trap logic and the instruction ROM/IF-ID register.

## Interface
- XLEN, 32, PC width in bits
- RESET_ADDR, 0, PC value loaded on reset
- INC, 4, sequential increment; legal values 2 or 4
- ALIGN_CHECK, 1, 1 = check redirect targets for alignment
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- hold_i  in  1  pipeline stall; blocks PC advance
- jump_en_i  in  1  jump/branch redirect request from execute
- jump_addr_i  in  XLEN  jump target
- trap_en_i  in  1  trap/exception redirect request; highest priority
- trap_addr_i  in  XLEN  trap vector
- pc_ready_i  in  1  fetch side accepts pc_o
- pc_valid_o  out  1  pc_o is a valid fetch request
- pc_o  out  XLEN  current fetch address
- redirect_o  out  1  one-cycle pulse: pc_o holds a freshly redirected target (flush IF/ID)
- misalign_o  out  1  level: core is in FAULT because of a misaligned jump target

## Operation
**States:** BOOT, RUN, FAULT.

**Reset (async, rst_n=0):**
- State → BOOT.
- pc_o=RESET_ADDR, pc_valid_o=0, redirect_o=0, misalign_o=0.
- Pending-redirect register cleared.

**BOOT:**
- Lasts exactly one cycle, then → RUN.
- A trap_en_i seen during BOOT is applied as in RUN.

**pc_valid_o:** = (state==RUN) && !hold_i && !pend_valid.
- hold_i may retract a request. The ROM is stateless, so this is permitted.

**Sequential advance:**
- On pc_valid_o && pc_ready_i with no redirect: pc_o <= pc_o + INC.
- Arithmetic is modulo 2^XLEN, so all-ones−INC+1 wraps to 0.
- While pc_valid_o && !pc_ready_i with no redirect, pc_o is stable.

**Redirect selection:** trap_en_i > jump_en_i > pending register.
- Trap target has its low log2(INC) bits forced to 0.

**Redirect with hold_i=0:**
- Load pc_o with the target.
- Set redirect_o=1 for the next cycle.
- A handshake completing in the same cycle counts as consumed; there is no replay.

**Redirect with hold_i=1:**
- Capture into the pending register instead of loading pc_o.
- A later trap overwrites a pending jump.
- A later jump does not overwrite a pending trap.
- The pending redirect is applied at the first edge where hold_i=0.

**Misalignment (ALIGN_CHECK=1):**
- A jump target with low log2(INC) bits ≠0 is not loaded.
- State → FAULT, misalign_o=1.
- pc_o keeps the last valid value; pc_valid_o=0.

**FAULT:**
- Exits only on trap_en_i: load trap target, → RUN, misalign_o=0, redirect_o pulse.
- jump_en_i is ignored in FAULT.

## Timing
- Redirect request at edge N → pc_o=target and redirect_o=1 during cycle N+1. redirect_o returns to 0 at N+2 unless there is another redirect.
- Request throughput is 1 PC per cycle when pc_ready_i=1 and hold_i=0.
- Held redirect → pc_o=target one cycle after the first hold_i=0 cycle. pc_valid_o stays 0 until then.
- Reset to first valid request: 1 cycle (BOOT). pc_valid_o=1 from the second cycle after reset release.
- rst_n assertion mid-request drops the request and any pending redirect immediately (async).

## Structure
- Shared package `pc_pkg`:
  - state enum {BOOT, RUN, FAULT};
  - localparam for ALIGN_LSB = $clog2(INC);
  - INC legality check constant.
- Redirect priority/pending logic may be a sub-module `pc_redirect_arb`. Its inputs are trap/jump/pending/hold; its outputs are the selected target, load strobe and pending update.
- The PC register, FSM and handshake stay in pc_gen.

## Test plan
- **Reset/boot:** RESET_ADDR=0x100; release rst_n with pc_ready_i=1 → BOOT 1 cycle, then pc_o=0x100, 0x104, 0x108 with pc_valid_o=1.
- **Backpressure:** pc_ready_i=0 for 3 cycles at pc_o=0x20 → pc_o stays 0x20 and valid stays 1; after ready, next pc_o=0x24.
- **Priority:** jump 0x400 and trap 0x800 in the same cycle → pc_o=0x800, redirect_o=1 for one cycle.
- **Held redirect:** with hold_i=1, jump 0x40 then trap 0x80 → nothing changes during hold; on release pc_o=0x80 and 0x40 is never issued.
- **Misalign:** jump to 0x102 (INC=4) → misalign_o=1, pc_valid_o=0, pc_o unchanged; a later jump is ignored; trap 0x200 → RUN at pc_o=0x200.
- **Wrap and reset:** pc_o=0xFFFFFFFC advances to 0x0; assert rst_n low mid-hold with a pending trap → outputs reset and the trap is not applied after release.
